// File: rtl/mem_bus_arbiter.sv
// 2:1 req/gnt arbiter sharing one memory port between instruction fetch and load/store.
// Define MEM_BUS_ARBITER_FAIR_EN to add the dmem grant-streak limiter (anti-starvation).
module mem_bus_arbiter #(
  parameter int MEM_ADDR_W = 64,
  parameter int MEM_STRB_W = 8,
  parameter int MEM_DATA_W = 64,
  parameter int MAX_DGNT   = 4
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  imem_req,
  input  logic [MEM_ADDR_W-1:0] imem_addr,
  input  logic                  imem_wen,
  input  logic [MEM_STRB_W-1:0] imem_strb,
  input  logic [MEM_DATA_W-1:0] imem_wdata,
  output logic                  imem_gnt,
  output logic                  imem_err,
  output logic [MEM_DATA_W-1:0] imem_rdata,
  input  logic                  dmem_req,
  input  logic [MEM_ADDR_W-1:0] dmem_addr,
  input  logic                  dmem_wen,
  input  logic [MEM_STRB_W-1:0] dmem_strb,
  input  logic [MEM_DATA_W-1:0] dmem_wdata,
  output logic                  dmem_gnt,
  output logic                  dmem_err,
  output logic [MEM_DATA_W-1:0] dmem_rdata,
  output logic                  mem_req,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [MEM_STRB_W-1:0] mem_strb,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_err,
  input  logic [MEM_DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD_I = 2'd1;
  localparam logic [1:0] HOLD_D = 2'd2;

  logic [1:0] state_q, state_d;
  logic [1:0] rsp_own_q, rsp_own_d;
  logic       sel_i, sel_d;
  logic       favor_i;

`ifdef MEM_BUS_ARBITER_FAIR_EN
  localparam logic [3:0] MaxDgnt = 4'(MAX_DGNT);
  logic [3:0] dstreak_q, dstreak_d;

  assign favor_i = imem_req && (dstreak_q >= MaxDgnt);

  always_comb begin
    dstreak_d = dstreak_q;
    if (imem_gnt || !imem_req) begin
      dstreak_d = 4'd0;
    end else if (dmem_gnt && (dstreak_q != 4'hF)) begin
      dstreak_d = dstreak_q + 4'd1;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      dstreak_q <= 4'd0;
    end else begin
      dstreak_q <= dstreak_d;
    end
  end
`else
  logic unused_max_dgnt;
  assign favor_i         = 1'b0;
  assign unused_max_dgnt = (MAX_DGNT != 0);
`endif

  // A held request stays locked to its owner; a dropped one simply selects nobody.
  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    case (state_q)
      HOLD_I:  sel_i = imem_req;
      HOLD_D:  sel_d = dmem_req;
      default: begin
        sel_d = dmem_req && !favor_i;
        sel_i = imem_req && !sel_d;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sel_d && !mem_gnt) begin
          state_d = HOLD_D;
        end else if (sel_i && !mem_gnt) begin
          state_d = HOLD_I;
        end
      end
      HOLD_I:  if (mem_gnt || !imem_req) state_d = IDLE;
      HOLD_D:  if (mem_gnt || !dmem_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_req   = sel_i || sel_d;
  assign mem_addr  = sel_d ? dmem_addr  : (sel_i ? imem_addr  : '0);
  assign mem_wen   = sel_d ? dmem_wen   : (sel_i ? imem_wen   : 1'b0);
  assign mem_strb  = sel_d ? dmem_strb  : (sel_i ? imem_strb  : '0);
  assign mem_wdata = sel_d ? dmem_wdata : (sel_i ? imem_wdata : '0);

  assign imem_gnt  = mem_gnt && sel_i;
  assign dmem_gnt  = mem_gnt && sel_d;

  // Bit 1 marks an imem response due next cycle, bit 0 a dmem response.
  assign rsp_own_d = {sel_i && mem_req && mem_gnt, sel_d && mem_req && mem_gnt};

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q   <= IDLE;
      rsp_own_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      rsp_own_q <= rsp_own_d;
    end
  end

  assign imem_err   = mem_err && rsp_own_q[1];
  assign dmem_err   = mem_err && rsp_own_q[0];
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them and flags any grant nobody expected.
module tb_mem_bus_arbiter;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        imem_req, imem_wen, imem_gnt, imem_err;
  logic [63:0] imem_addr, imem_wdata, imem_rdata;
  logic [7:0]  imem_strb;
  logic        dmem_req, dmem_wen, dmem_gnt, dmem_err;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_strb;
  logic        mem_req, mem_wen, mem_gnt, mem_err;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_strb;

  mem_bus_arbiter #(
    .MEM_ADDR_W(64), .MEM_STRB_W(8), .MEM_DATA_W(64), .MAX_DGNT(4)
  ) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_wen(imem_wen),
    .imem_strb(imem_strb), .imem_wdata(imem_wdata),
    .imem_gnt(imem_gnt), .imem_err(imem_err), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_strb(mem_strb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_err(mem_err), .mem_rdata(mem_rdata)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    int          cyc;
    string       name;
    logic        ig, dg, mreq, mwen, ie, de;
    logic [63:0] maddr, rdata;
  } exp_t;

  exp_t        expQ[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [63:0] lastRdata = '0;

  always @(posedge g_clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, want);
    end
  endfunction

  task automatic applyStimulus(input logic ir, input logic [63:0] ia,
                               input logic dr, input logic [63:0] da, input logic dw,
                               input logic gnt, input logic err, input logic [63:0] rd);
    @(posedge g_clk);
    #1;
    imem_req  = ir;
    imem_addr = ia;
    dmem_req  = dr;
    dmem_addr = da;
    dmem_wen  = dw;
    mem_gnt   = gnt;
    mem_err   = err;
    mem_rdata = rd;
    lastRdata = rd;
  endtask

  task automatic checkOutput(input string name, input logic ig, input logic dg,
                             input logic mreq, input logic mwen, input logic [63:0] maddr,
                             input logic ie, input logic de);
    exp_t e;
    e.cyc   = cyc;
    e.name  = name;
    e.ig    = ig;
    e.dg    = dg;
    e.mreq  = mreq;
    e.mwen  = mwen;
    e.maddr = maddr;
    e.ie    = ie;
    e.de    = de;
    e.rdata = lastRdata;
    expQ.push_back(e);
  endtask

  // Monitor: compares whatever the scoreboard holds for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge g_clk);
      if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
        e = expQ.pop_front();
        check({e.name, ".imem_gnt"},   64'(imem_gnt),  64'(e.ig));
        check({e.name, ".dmem_gnt"},   64'(dmem_gnt),  64'(e.dg));
        check({e.name, ".mem_req"},    64'(mem_req),   64'(e.mreq));
        check({e.name, ".mem_wen"},    64'(mem_wen),   64'(e.mwen));
        check({e.name, ".mem_addr"},   mem_addr,       e.maddr);
        check({e.name, ".imem_err"},   64'(imem_err),  64'(e.ie));
        check({e.name, ".dmem_err"},   64'(dmem_err),  64'(e.de));
        check({e.name, ".imem_rdata"}, imem_rdata,     e.rdata);
        check({e.name, ".dmem_rdata"}, dmem_rdata,     e.rdata);
      end else if (imem_gnt || dmem_gnt) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_gnt: got imem_gnt=%b dmem_gnt=%b want 0 0 at cycle %0d",
                 imem_gnt, dmem_gnt, cyc);
      end
    end
  end

  initial begin
    logic isI;
    g_reset    = 1'b1;
    imem_req   = 1'b0; imem_addr = '0; imem_wen = 1'b0; imem_strb = 8'hFF; imem_wdata = '0;
    dmem_req   = 1'b0; dmem_addr = '0; dmem_wen = 1'b0; dmem_strb = 8'h0F;
    dmem_wdata = 64'h0123_4567_89AB_CDEF;
    mem_gnt    = 1'b0; mem_err = 1'b0; mem_rdata = '0;

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h55);
    checkOutput("rst_hold", 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h66);
    g_reset = 1'b0;
    checkOutput("rst_release", 0, 0, 0, 0, 0, 0, 0);

    applyStimulus(1, 64'h1000, 0, 0, 0, 1, 0, 0);
    checkOutput("fetch_gnt", 1, 0, 1, 0, 64'h1000, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 64'hDEAD);
    checkOutput("fetch_rsp", 0, 0, 0, 0, 0, 0, 0);

    applyStimulus(1, 64'h2000, 1, 64'h3000, 0, 1, 0, 0);
    checkOutput("cont_d", 0, 1, 1, 0, 64'h3000, 0, 0);
    applyStimulus(1, 64'h2000, 0, 0, 0, 1, 1, 64'h11);
    checkOutput("cont_i", 1, 0, 1, 0, 64'h2000, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h22);
    checkOutput("cont_irsp", 0, 0, 0, 0, 0, 1, 0);

    applyStimulus(1, 64'h4000, 0, 0, 0, 0, 0, 0);
    checkOutput("hold0", 0, 0, 1, 0, 64'h4000, 0, 0);
    applyStimulus(1, 64'h4000, 1, 64'h5000, 1, 0, 0, 0);
    checkOutput("hold1", 0, 0, 1, 0, 64'h4000, 0, 0);
    applyStimulus(1, 64'h4000, 1, 64'h5000, 1, 0, 0, 0);
    checkOutput("hold2", 0, 0, 1, 0, 64'h4000, 0, 0);
    applyStimulus(1, 64'h4000, 1, 64'h5000, 1, 1, 0, 0);
    checkOutput("hold_gi", 1, 0, 1, 0, 64'h4000, 0, 0);
    applyStimulus(0, 0, 1, 64'h5000, 1, 1, 0, 0);
    checkOutput("hold_gd", 0, 1, 1, 1, 64'h5000, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h33);
    checkOutput("hold_drsp", 0, 0, 0, 0, 0, 0, 1);

    // Async reset out of HOLD_I lets dmem win immediately, without a clock edge.
    applyStimulus(1, 64'h7000, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_lock0", 0, 0, 1, 0, 64'h7000, 0, 0);
    applyStimulus(1, 64'h7000, 1, 64'h8000, 1, 0, 0, 0);
    checkOutput("rst_lock1", 0, 0, 1, 0, 64'h7000, 0, 0);
    @(negedge g_clk);
    #1;
    g_reset = 1'b1;
    #1;
    check("async_rst_addr", mem_addr, 64'h8000);
    check("async_rst_wen", 64'(mem_wen), 64'h1);
    applyStimulus(0, 0, 1, 64'h9000, 0, 1, 0, 0);
    g_reset = 1'b0;
    checkOutput("rst_dgnt", 0, 1, 1, 0, 64'h9000, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h44);
    #1;
    check("rsp_before_rst", 64'(dmem_err), 64'h1);
    g_reset = 1'b1;
    #1;
    check("async_rsp_clr", 64'(dmem_err), 64'h0);
    checkOutput("rst_rsp", 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h45);
    g_reset = 1'b0;
    checkOutput("rsp_discard", 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 64'hA000, 1, 64'hB000, 0, 1, 0, 0);
`ifdef MEM_BUS_ARBITER_FAIR_EN
      isI = ((i % 5) == 4);
`else
      isI = 1'b0;
`endif
      checkOutput($sformatf("fair%0d", i), isI, !isI, 1, 0, isI ? 64'hA000 : 64'hB000, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fair_end", 0, 0, 0, 0, 0, 0, 0);

    applyStimulus(1, 64'hC000, 0, 0, 0, 0, 0, 0);
    checkOutput("drop0", 0, 0, 1, 0, 64'hC000, 0, 0);
    applyStimulus(0, 0, 1, 64'hD000, 0, 1, 0, 0);
    checkOutput("drop1", 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 64'hD000, 0, 1, 0, 0);
    checkOutput("drop_d", 0, 1, 1, 0, 64'hD000, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("drop_end", 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge g_clk);
    #1;
    check("queue_drain", 64'(expQ.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
